// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption sequencer and its datapath mux.
package aes_ctrl_pkg;

    // Sequencer states, in the order the inverse cipher visits them.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_KEY_EXP  = 4'd1,
        S_INIT_ARK = 4'd2,
        S_R_ISR    = 4'd3,
        S_R_ISB    = 4'd4,
        S_R_ARK    = 4'd5,
        S_R_IMC    = 4'd6,
        S_F_ISR    = 4'd7,
        S_F_ISB    = 4'd8,
        S_F_ARK    = 4'd9,
        S_WRITE    = 4'd10,
        S_DONE     = 4'd11
    } aes_state_e;

    // Operation select codes seen by the state-register input mux.
    localparam logic [1:0] OP_ARK = 2'd0;
    localparam logic [1:0] OP_ISR = 2'd1;
    localparam logic [1:0] OP_ISB = 2'd2;
    localparam logic [1:0] OP_IMC = 2'd3;

    // AES-128 round count and the number of columns InvMixColumns walks through.
    localparam int NUM_ROUNDS = 10;
    localparam int IMC_COLS   = 4;

endpackage

// File: rtl/aes_decrypt_control_if.sv
// Control bundle between the decryption sequencer and the Avalon-MM register block / datapath.
interface aes_decrypt_control_if;
    import aes_ctrl_pkg::*;

    // Start/done handshake: AES_START is a level from the Start register. A rising
    // level seen in IDLE launches one decryption; AES_DONE then stays high for as long
    // as AES_START stays high, and drops the cycle after AES_START is seen low.
    // A new operation only begins once AES_START has been low and rises again.
    logic       AES_START;
    logic       AES_DONE;
    logic       BUSY;
    logic       LD_MSG;
    logic       LD_STATE;
    logic [1:0] OP_SEL;
    logic [3:0] RK_IDX;
    logic [1:0] COL_SEL;
    logic       LD_DEC;

    // Sequencer internals exposed for observation.
    aes_state_e state_dbg;
    logic [3:0] round_dbg;

    // Sequencer side.
    modport master (
        input  AES_START,
        output AES_DONE, BUSY, LD_MSG, LD_STATE, OP_SEL, RK_IDX, COL_SEL, LD_DEC,
        output state_dbg, round_dbg
    );

    // Register block / datapath side.
    modport slave (
        output AES_START,
        input  AES_DONE, BUSY, LD_MSG, LD_STATE, OP_SEL, RK_IDX, COL_SEL, LD_DEC,
        input  state_dbg, round_dbg
    );

endinterface

// File: rtl/aes_decrypt_control.sv
// Moore sequencer stepping the shared AES-128 state register through the inverse cipher.
module aes_decrypt_control #(
    parameter int KEY_EXP_CYCLES = 12,
    parameter int NUM_ROUNDS     = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    aes_decrypt_control_if.master bus
);
    import aes_ctrl_pkg::*;

    localparam int KW = (KEY_EXP_CYCLES > 1) ? $clog2(KEY_EXP_CYCLES) : 1;
    localparam logic [KW-1:0] KEXP_LAST  = KW'(KEY_EXP_CYCLES - 1);
    localparam logic [3:0]    ROUND_INIT = 4'(NUM_ROUNDS - 1);
    localparam logic [1:0]    COL_LAST   = 2'(IMC_COLS - 1);

    aes_state_e    state, state_nx;
    logic [KW-1:0] kexp_cnt;
    logic [3:0]    round;
    logic [1:0]    col;

    logic       aes_done_c, busy_c, ld_msg_c, ld_state_c, ld_dec_c;
    logic [1:0] op_sel_c, col_sel_c;
    logic [3:0] rk_idx_c;

    // State register; reset wins over a start sampled on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Key-expansion wait, column and round counters; idle at zero outside their states.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            kexp_cnt <= '0;
            col      <= '0;
            round    <= '0;
        end else begin
            kexp_cnt <= (state == S_KEY_EXP) ? kexp_cnt + 1'b1 : '0;
            col      <= (state == S_R_IMC) ? col + 1'b1 : '0;
            if (state == S_INIT_ARK) begin
                round <= ROUND_INIT;
            end else if (state == S_R_IMC && col == COL_LAST) begin
                round <= round - 1'b1;
            end
        end
    end

    // Next-state logic and Moore outputs decoded from state and counters.
    always_comb begin
        state_nx   = state;
        aes_done_c = 1'b0;
        busy_c     = 1'b0;
        ld_msg_c   = 1'b0;
        ld_state_c = 1'b0;
        ld_dec_c   = 1'b0;
        op_sel_c   = OP_ARK;
        rk_idx_c   = 4'd0;
        col_sel_c  = 2'd0;
        unique case (state)
            S_IDLE: begin
                if (bus.AES_START) state_nx = S_KEY_EXP;
            end
            S_KEY_EXP: begin
                busy_c   = 1'b1;
                ld_msg_c = (kexp_cnt == '0);
                if (kexp_cnt == KEXP_LAST) state_nx = S_INIT_ARK;
            end
            S_INIT_ARK: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ARK;
                rk_idx_c   = 4'(NUM_ROUNDS);
                state_nx   = S_R_ISR;
            end
            S_R_ISR: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ISR;
                state_nx   = S_R_ISB;
            end
            S_R_ISB: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ISB;
                state_nx   = S_R_ARK;
            end
            S_R_ARK: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ARK;
                rk_idx_c   = round;
                state_nx   = S_R_IMC;
            end
            S_R_IMC: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_IMC;
                col_sel_c  = col;
                if (col == COL_LAST) state_nx = (round > 4'd1) ? S_R_ISR : S_F_ISR;
            end
            S_F_ISR: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ISR;
                state_nx   = S_F_ISB;
            end
            S_F_ISB: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ISB;
                state_nx   = S_F_ARK;
            end
            S_F_ARK: begin
                busy_c     = 1'b1;
                ld_state_c = 1'b1;
                op_sel_c   = OP_ARK;
                rk_idx_c   = 4'd0;
                state_nx   = S_WRITE;
            end
            S_WRITE: begin
                busy_c   = 1'b1;
                ld_dec_c = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                aes_done_c = 1'b1;
                if (!bus.AES_START) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.AES_DONE  = aes_done_c;
    assign bus.BUSY      = busy_c;
    assign bus.LD_MSG    = ld_msg_c;
    assign bus.LD_STATE  = ld_state_c;
    assign bus.OP_SEL    = op_sel_c;
    assign bus.RK_IDX    = rk_idx_c;
    assign bus.COL_SEL   = col_sel_c;
    assign bus.LD_DEC    = ld_dec_c;
    assign bus.state_dbg = state;
    assign bus.round_dbg = round;

endmodule

// File: tb/tb_aes_decrypt_control.sv
// Self-checking bench: cycle schedule model plus an AES-128 reference datapath driven by the controls.
module tb_aes_decrypt_control;

    localparam int K = 12;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_decrypt_control_if bus ();

    aes_decrypt_control #(.KEY_EXP_CYCLES(K), .NUM_ROUNDS(10)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.master)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- AES reference ----------------
    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [31:0] w   [44];
    logic [7:0]  st  [16];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gm(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic build_ref();
        logic [31:0] tmp;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 256; i++) begin
            sb[i] = sbox_calc(8'(i));
            isb[sb[i]] = 8'(i);
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
    endtask

    function automatic logic [127:0] pack_state();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = st[i];
        return v;
    endfunction

    task automatic apply_op(input logic [1:0] op, input logic [3:0] rk, input logic [1:0] c);
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        int rki;
        rki = (rk > 4'd10) ? 0 : int'(rk);
        case (op)
            2'd0: for (int cc = 0; cc < 4; cc++)
                      for (int r = 0; r < 4; r++)
                          st[r + 4*cc] = st[r + 4*cc] ^ w[4*rki + cc][31 - 8*r -: 8];
            2'd1: begin
                t = st;
                for (int cc = 0; cc < 4; cc++)
                    for (int r = 0; r < 4; r++)
                        st[r + 4*cc] = t[r + 4*((cc - r + 4) % 4)];
            end
            2'd2: for (int i = 0; i < 16; i++) st[i] = isb[st[i]];
            default: begin
                a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                st[4*c]   = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
                st[4*c+1] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
                st[4*c+2] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
                st[4*c+3] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
            end
        endcase
    endtask

    // ---------------- schedule model ----------------
    // mode 0 idle, 1 running (t = cycles since first KEY_EXP cycle), 2 done.
    int mode = 0;
    int t    = 0;
    bit model_valid = 1'b0;
    int n_ops_exp = 0;
    int n_dec = 0;
    int lds_cnt = 0;

    // Expected {AES_DONE,BUSY,LD_MSG,LD_STATE,OP_SEL,RK_IDX,COL_SEL,LD_DEC} for a cycle.
    function automatic logic [12:0] exp_outs(input int m, input int tt);
        logic done = 0, busy = 0, ldm = 0, lds = 0, ldd = 0;
        logic [1:0] op = 0, col = 0;
        logic [3:0] rk = 0;
        int u;
        if (m == 2) begin
            done = 1;
        end else if (m == 1) begin
            busy = 1;
            if (tt < K) begin
                ldm = (tt == 0);
            end else if (tt == K) begin
                lds = 1; rk = 4'd10;
            end else if (tt <= K + 63) begin
                u = tt - K - 1;
                lds = 1;
                case (u % 7)
                    0: op = 2'd1;
                    1: op = 2'd2;
                    2: begin op = 2'd0; rk = 4'(9 - u / 7); end
                    default: begin op = 2'd3; col = 2'((u % 7) - 3); end
                endcase
            end else if (tt == K + 64) begin
                lds = 1; op = 2'd1;
            end else if (tt == K + 65) begin
                lds = 1; op = 2'd2;
            end else if (tt == K + 66) begin
                lds = 1; op = 2'd0;
            end else begin
                ldd = 1;
            end
        end
        return {done, busy, ldm, lds, op, rk, col, ldd};
    endfunction

    logic start = 1'b0;
    logic [12:0] obs;

    assign bus.AES_START = start;

    // Per-cycle compare, reference datapath update and model advance, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            obs = {bus.AES_DONE, bus.BUSY, bus.LD_MSG, bus.LD_STATE, bus.OP_SEL,
                   bus.RK_IDX, bus.COL_SEL, bus.LD_DEC};
            check($sformatf("outs mode%0d t%0d", mode, t), 128'(obs), 128'(exp_outs(mode, t)));
        end
        if (bus.LD_DEC === 1'b1) begin
            check("ld_state_count", 128'(lds_cnt), 128'd67);
            check("plaintext", pack_state(), PT);
            n_dec++;
        end
        if (bus.LD_MSG === 1'b1) begin
            for (int i = 0; i < 16; i++) st[i] = CT[127 - 8*i -: 8];
            lds_cnt = 0;
        end else if (bus.LD_STATE === 1'b1) begin
            apply_op(bus.OP_SEL, bus.RK_IDX, bus.COL_SEL);
            lds_cnt++;
        end
        if (rst) begin
            mode = 0; t = 0; model_valid = 1'b1;
        end else begin
            case (mode)
                0: if (start) begin mode = 1; t = 0; end
                1: if (t == K + 67) begin mode = 2; n_ops_exp++; end else t++;
                default: if (!start) mode = 0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise START for 'pulse' cycles (or through DONE if longer), wait for DONE, then
    // hold START a further 'extra' cycles before dropping it.
    task automatic run_op(input int pulse, input int extra);
        int cnt = 0;
        bit seen = 1'b0;
        start = 1'b1;
        while (!seen && cnt < 200) begin
            tick();
            cnt++;
            if (cnt == pulse) start = 1'b0;
            if (bus.AES_DONE === 1'b1) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 128'd0, 128'd1);
        if (start) begin
            repeat (extra) tick();
            start = 1'b0;
        end
        repeat (3) tick();
    endtask

    // Start an operation and hit RESET at the end of cycle 'at'.
    task automatic abort_op(input int at);
        start = 1'b1;
        for (int i = 0; i < at + 1; i++) begin
            tick();
            if (i == 2) start = 1'b0;
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        build_ref();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Short start pulse, full operation.
        run_op(1, 0);
        // START held through DONE for 20 cycles, then dropped; then re-raised.
        run_op(1000, 20);
        run_op($urandom_range(2, 40), 0);
        // Reset mid-operation at cycle 40, then a fresh operation.
        abort_op(40);
        repeat ($urandom_range(1, 6)) tick();
        run_op(3, 0);
        // Start asserted together with reset: reset wins, start taken the next cycle.
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        run_op(4, 0);

        for (int it = 0; it < 5; it++) begin
            kind = $urandom_range(0, 2);
            repeat ($urandom_range(0, 5)) tick();
            case (kind)
                0: run_op($urandom_range(1, 80), 0);
                1: run_op(1000, $urandom_range(0, 10));
                default: begin
                    abort_op($urandom_range(1, 78));
                    run_op($urandom_range(1, 10), 0);
                end
            endcase
        end

        repeat (2) tick();
        check("completed_ops", 128'(n_dec), 128'(n_ops_exp));
        check("ops_nonzero", 128'(n_dec > 5), 128'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
